// File: rtl/wb_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with saturating statistics.
// Block memory is external; the controller drives a block-wide request/handshake port set.
module wb_cache_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int WORDS  = 4,
   parameter int LINES  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           read,
   input  logic                           write,
   input  logic [ADDR_W-1:0]              address,
   input  logic [DATA_W-1:0]              writedata,
   output logic [DATA_W-1:0]              readdata,
   output logic                           busywait,
   output logic                           mem_read,
   output logic                           mem_write,
   output logic [ADDR_W-$clog2(WORDS)-1:0] mem_address,
   output logic [DATA_W*WORDS-1:0]        mem_writedata,
   input  logic [DATA_W*WORDS-1:0]        mem_readdata,
   input  logic                           mem_busywait,
   output logic [CNT_W-1:0]               hit_count,
   output logic [CNT_W-1:0]               miss_count,
   output logic [CNT_W-1:0]               wb_count
);
   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam int BLK_W = DATA_W * WORDS;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WB = 2'd1, S_ALLOC = 2'd2} state_e;

   state_e             state_q, state_d;
   logic               first_q, first_d;
   logic [DATA_W-1:0]  rdata_q;
   logic [CNT_W-1:0]   hit_q, miss_q, wbc_q;
   logic [LINES-1:0]   valid_q, dirty_q;
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [BLK_W-1:0]   data_q [LINES];

   logic [TAG_W-1:0]   tag_s;
   logic [IDX_W-1:0]   idx_s;
   logic [OFF_W-1:0]   off_s;
   logic [BLK_W-1:0]   line_s;
   logic [DATA_W-1:0]  word_s;
   logic               req_s, hit_s;
   logic               hit_ev_s, miss_ev_s, wb_ev_s, rd_hit_s, wr_hit_s, fill_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
   endfunction

   assign tag_s  = address[ADDR_W-1 -: TAG_W];
   assign idx_s  = address[OFF_W +: IDX_W];
   assign off_s  = address[OFF_W-1:0];
   assign line_s = data_q[idx_s];
   assign word_s = line_s[DATA_W*off_s +: DATA_W];
   assign req_s  = read | write;
   assign hit_s  = valid_q[idx_s] && (tag_q[idx_s] == tag_s);

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
   assign wb_count   = wbc_q;

   // Next-state and output decode; transfer states ignore the handshake on their first cycle.
   always_comb begin
      state_d       = state_q;
      first_d       = 1'b0;
      busywait      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = '0;
      mem_writedata = '0;
      readdata      = rdata_q;
      hit_ev_s      = 1'b0;
      miss_ev_s     = 1'b0;
      wb_ev_s       = 1'b0;
      rd_hit_s      = 1'b0;
      wr_hit_s      = 1'b0;
      fill_s        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_s && hit_s) begin
               hit_ev_s = 1'b1;
               if (write) begin
                  wr_hit_s = 1'b1;
               end else begin
                  rd_hit_s = 1'b1;
                  readdata = word_s;
               end
            end else if (req_s) begin
               busywait  = 1'b1;
               miss_ev_s = 1'b1;
               first_d   = 1'b1;
               if (valid_q[idx_s] && dirty_q[idx_s]) begin
                  wb_ev_s = 1'b1;
                  state_d = S_WB;
               end else begin
                  state_d = S_ALLOC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WB: begin
            busywait      = 1'b1;
            mem_write     = 1'b1;
            mem_address   = {tag_q[idx_s], idx_s};
            mem_writedata = line_s;
            if (!first_q && !mem_busywait) begin
               state_d = S_ALLOC;
               first_d = 1'b1;
            end else begin
               state_d = S_WB;
            end
         end
         S_ALLOC: begin
            busywait    = 1'b1;
            mem_read    = 1'b1;
            mem_address = {tag_s, idx_s};
            if (!first_q && !mem_busywait) begin
               fill_s  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_ALLOC;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state, line status bits, load data register and statistics.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_IDLE;
         first_q <= 1'b0;
         rdata_q <= '0;
         valid_q <= '0;
         dirty_q <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
         wbc_q   <= '0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
         rdata_q <= rd_hit_s ? word_s : rdata_q;
         hit_q   <= sat_inc(hit_q, hit_ev_s);
         miss_q  <= sat_inc(miss_q, miss_ev_s);
         wbc_q   <= sat_inc(wbc_q, wb_ev_s);
         if (fill_s) begin
            valid_q[idx_s] <= 1'b1;
            dirty_q[idx_s] <= 1'b0;
         end else if (wr_hit_s) begin
            dirty_q[idx_s] <= 1'b1;
         end else begin
            dirty_q <= dirty_q;
         end
      end
   end

   // Tag and data arrays are not cleared, but reset still blocks any update.
   always_ff @(posedge clock) begin
      if (reset && fill_s) begin
         data_q[idx_s] <= mem_readdata;
         tag_q[idx_s]  <= tag_s;
      end else if (reset && wr_hit_s) begin
         data_q[idx_s][DATA_W*off_s +: DATA_W] <= writedata;
      end
   end
endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Randomised self-checking bench for wb_cache_ctrl against a line/word-level cache model
// and a byte-addressed memory model; a small memory responder drives the handshake.
module tb_wb_cache_ctrl;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        read = 1'b0, write = 1'b0;
   logic [7:0]  address = 8'h00, writedata = 8'h00;
   logic [7:0]  readdata;
   logic        busywait, mem_read, mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata, mem_readdata;
   logic        mem_busywait = 1'b0;
   logic [15:0] hit_count, miss_count, wb_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   wb_cache_ctrl dut (
      .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
      .writedata(writedata), .readdata(readdata), .busywait(busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
      .mem_busywait(mem_busywait), .hit_count(hit_count), .miss_count(miss_count),
      .wb_count(wb_count)
   );

   // Memory responder: busy for a set number of cycles from the first cycle of each transfer.
   logic [31:0] bmem [64];
   int          alloc_busy = 2, wb_busy = 2;
   int          kind_cur = 0, rem = 0;
   bit          wb_seen, alloc_seen;
   logic [5:0]  wb_addr_seen, alloc_addr_seen;
   logic [31:0] wb_data_seen;

   assign mem_readdata = bmem[mem_address];

   always @(negedge clock) begin
      int k;
      k = mem_write ? 1 : (mem_read ? 2 : 0);
      if (k == 0) begin
         kind_cur = 0; rem = 0; mem_busywait = 1'b0;
      end else if (k != kind_cur) begin
         kind_cur = k;
         rem = (k == 1) ? wb_busy : alloc_busy;
         mem_busywait = 1'b1;
         if (k == 1) begin
            wb_seen = 1'b1; wb_addr_seen = mem_address; wb_data_seen = mem_writedata;
         end else begin
            alloc_seen = 1'b1; alloc_addr_seen = mem_address;
         end
      end else if (rem > 0) begin
         rem--;
         if (rem == 0) begin
            mem_busywait = 1'b0;
            if (k == 1) bmem[mem_address] = mem_writedata;
         end
      end
   end

   // Reference model state
   bit          m_valid [8];
   bit          m_dirty [8];
   logic [2:0]  m_tag   [8];
   logic [7:0]  m_data  [8][4];
   logic [7:0]  ref_mem [256];
   int          e_hit = 0, e_miss = 0, e_wb = 0;
   logic [7:0]  obs_rd;
   int          obs_lat;

   task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tg, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
      end
      e_hit = 0; e_miss = 0; e_wb = 0;
   endtask

   task automatic do_access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd);
      logic [2:0]  t, i;
      logic [1:0]  o;
      bit          h, dty;
      int          exp_lat;
      logic [7:0]  exp_rd;
      logic [5:0]  e_wb_addr;
      logic [31:0] e_wb_data;
      t = a[7:5]; i = a[4:2]; o = a[1:0];
      h   = m_valid[i] && (m_tag[i] == t);
      dty = !h && m_valid[i] && m_dirty[i];
      exp_lat = 0; exp_rd = 8'h00; e_wb_addr = 6'h00; e_wb_data = 32'h0;
      if (!h) begin
         e_miss++;
         exp_lat = 2 + alloc_busy;
         if (dty) begin
            e_wb++;
            exp_lat += 1 + wb_busy;
            e_wb_addr = {m_tag[i], i};
            for (int k = 0; k < 4; k++) begin
               ref_mem[{m_tag[i], i, 2'(k)}] = m_data[i][k];
               e_wb_data[8*k +: 8] = m_data[i][k];
            end
         end
         for (int k = 0; k < 4; k++) m_data[i][k] = ref_mem[{t, i, 2'(k)}];
         m_valid[i] = 1'b1; m_dirty[i] = 1'b0; m_tag[i] = t;
      end
      e_hit++;
      if (wr) begin
         m_data[i][o] = wd; m_dirty[i] = 1'b1;
      end else begin
         exp_rd = m_data[i][o];
      end

      wb_seen = 1'b0; alloc_seen = 1'b0;
      @(negedge clock);
      read = rd; write = wr; address = a; writedata = wd;
      obs_lat = 0;
      #1;
      while (busywait === 1'b1 && obs_lat < 200) begin
         obs_lat++;
         @(negedge clock); #1;
      end
      chk("latency", 32'(obs_lat), 32'(exp_lat));
      obs_rd = readdata;
      if (!wr) chk("readdata", readdata, exp_rd);
      @(posedge clock);
      @(negedge clock);
      read = 1'b0; write = 1'b0;
      #1;
      chk("hit_count", hit_count, 32'(e_hit));
      chk("miss_count", miss_count, 32'(e_miss));
      chk("wb_count", wb_count, 32'(e_wb));
      if (!wr) chk("rd_hold", readdata, exp_rd);
      chk("alloc_seen", alloc_seen, !h);
      if (!h) chk("alloc_addr", alloc_addr_seen, {t, i});
      chk("wb_seen", wb_seen, dty);
      if (dty) begin
         chk("wb_addr", wb_addr_seen, e_wb_addr);
         chk("wb_data", wb_data_seen, e_wb_data);
      end
   endtask

   initial begin
      logic [31:0] v;
      logic [7:0]  ra;
      int          op;
      for (int b = 0; b < 64; b++) begin
         v = $urandom;
         bmem[b] = v;
         for (int k = 0; k < 4; k++) ref_mem[{6'(b), 2'(k)}] = v[8*k +: 8];
      end
      bmem[9] = 32'h44332211;
      ref_mem[8'h24] = 8'h11; ref_mem[8'h25] = 8'h22;
      ref_mem[8'h26] = 8'h33; ref_mem[8'h27] = 8'h44;
      model_reset();

      // Reset held for two edges
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busywait", busywait, 1'b0);
      chk("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_write", mem_write, 1'b0);
      chk("rst_mem_addr", mem_address, 6'h00);
      chk("rst_mem_wdata", mem_writedata, 32'h0);
      chk("rst_readdata", readdata, 8'h00);
      chk("rst_counters", {hit_count, miss_count} | 32'(wb_count), 32'h0);
      @(negedge clock);
      reset = 1'b1;

      // Directed walk-through
      do_access(1'b1, 1'b0, 8'h25, 8'h00);
      chk("dir_rd25", obs_rd, 8'h22);
      chk("dir_rd25_alloc", alloc_addr_seen, 6'h09);
      chk("dir_rd25_miss", miss_count, 16'd1);
      chk("dir_rd25_hit", hit_count, 16'd1);
      do_access(1'b1, 1'b0, 8'h24, 8'h00);
      chk("dir_rd24", obs_rd, 8'h11);
      chk("dir_rd24_lat", 32'(obs_lat), 32'd0);
      chk("dir_rd24_hit", hit_count, 16'd2);
      do_access(1'b0, 1'b1, 8'h26, 8'hAA);
      chk("dir_wr26_lat", 32'(obs_lat), 32'd0);
      do_access(1'b1, 1'b0, 8'h26, 8'h00);
      chk("dir_rd26", obs_rd, 8'hAA);
      do_access(1'b1, 1'b0, 8'hA6, 8'h00);
      chk("dir_wb_addr", wb_addr_seen, 6'h09);
      chk("dir_wb_data", wb_data_seen, 32'h44AA2211);
      chk("dir_alloc29", alloc_addr_seen, 6'h29);
      chk("dir_wb_cnt", wb_count, 16'd1);
      chk("dir_miss_cnt", miss_count, 16'd2);

      // Reset during ALLOCATE
      alloc_busy = 4;
      @(negedge clock);
      read = 1'b1; address = 8'h45;
      #1;
      for (int n = 0; n < 10 && mem_read !== 1'b1; n++) begin
         @(negedge clock); #1;
      end
      chk("rst_mid_reached", mem_read, 1'b1);
      @(negedge clock);
      reset = 1'b0; read = 1'b0;
      @(posedge clock);
      #1;
      chk("rst_mid_mem_read", mem_read, 1'b0);
      chk("rst_mid_busywait", busywait, 1'b0);
      chk("rst_mid_counters", {hit_count, miss_count} | 32'(wb_count), 32'h0);
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      alloc_busy = 2;
      do_access(1'b1, 1'b0, 8'h24, 8'h00);
      chk("post_rst_miss", 32'(obs_lat > 0), 32'd1);

      // Randomised traffic over a small tag range so hits, misses and write-backs mix
      for (int n = 0; n < 300; n++) begin
         alloc_busy = $urandom_range(1, 4);
         wb_busy    = $urandom_range(1, 4);
         op = $urandom_range(0, 9);
         ra = {1'b0, 7'($urandom)};
         do_access(op < 6 || op == 9, op >= 6, ra, 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
